// File: rtl/mk14_pkg.sv
// MK14 display/keyboard shared types and constants.
// Holds the decode base, key FSM states and the idle keypad value.
package mk14_pkg;

  localparam logic [15:0] DISP_BASE = 16'h0D00;
  localparam logic [7:0]  KEY_NONE  = 8'hFF;

  typedef enum logic [1:0] {
    K_IDLE,
    K_HELD,
    K_RELEASE
  } key_state_t;

`ifdef SIMULATION
  localparam bit SIM_MS = 1'b1;
`else
  localparam bit SIM_MS = 1'b0;
`endif

endpackage

// File: rtl/mk14_disp_kbd_if.sv
// Core memory-bus view of the display/keyboard block.
// master = core (address/write side), slave = responder (read side).
interface mk14_disp_kbd_if;

  logic        en;
  logic [15:0] mem_addr;
  logic        mem_write_en;
  logic [7:0]  mem_write_data;
  logic [7:0]  rd_data;
  logic        rd_hit;

  modport master (
    output en,
    output mem_addr,
    output mem_write_en,
    output mem_write_data,
    input  rd_data,
    input  rd_hit
  );

  modport slave (
    input  en,
    input  mem_addr,
    input  mem_write_en,
    input  mem_write_data,
    output rd_data,
    output rd_hit
  );

endinterface

// File: rtl/mk14_tick.sv
// Free-running divider: one-cycle tick every DIV clocks.
// Ports: clk, rst_n (sync, active-low), tick (out).
module mk14_tick #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // DIV == 1 leaves cnt pinned at 0, so tick is high every clock
  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mk14_disp_kbd.sv
// MK14 display latch, LED scan and keypad emulation at 0x0Dxx.
// Ports: clk, rst_n, bus (slave), key_strobe/key_code/key_busy, seg, dig_n.
module mk14_disp_kbd
  import mk14_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_MHZ = 50,
  parameter logic [15:0] BASE_ADDR      = DISP_BASE,
  parameter int unsigned DIGIT_US       = 1000,
  parameter int unsigned KEY_HOLD_MS    = 100,
  parameter int unsigned RELEASE_MS     = 50,
  parameter bit          SIM_TICK       = SIM_MS
) (
  input  logic             clk,
  input  logic             rst_n,
  mk14_disp_kbd_if.slave   bus,
  input  logic             key_strobe,
  input  logic [5:0]       key_code,
  output logic             key_busy,
  output logic [7:0]       seg,
  output logic [7:0]       dig_n
);

  localparam int unsigned MS_DIV =
    SIM_TICK ? 1 : CLOCK_FREQ_MHZ * 1000;
  localparam int unsigned DWELL_DIV =
    CLOCK_FREQ_MHZ * DIGIT_US;
  localparam int unsigned MS_MAX =
    (KEY_HOLD_MS > RELEASE_MS) ? KEY_HOLD_MS : RELEASE_MS;
  localparam int CW = $clog2(MS_MAX + 1);
  localparam logic [7:0] BASE_HI = BASE_ADDR[15:8];

  logic          ms_tick;
  logic          dwell_tick;
  logic          hit;
  logic [2:0]    digit;
  logic          unused;

  logic [7:0]    seg_latch [8];
  logic [2:0]    scan_idx;
  logic [2:0]    nxt_idx;
  logic          started;

  key_state_t    state;
  logic [2:0]    held_col;
  logic [2:0]    held_row;
  logic [CW-1:0] ms_cnt;

  mk14_tick #(.DIV(MS_DIV)) u_ms (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (ms_tick)
  );

  mk14_tick #(.DIV(DWELL_DIV)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (dwell_tick)
  );

  assign hit      = (bus.mem_addr[15:8] == BASE_HI);
  assign digit    = bus.mem_addr[2:0];
  assign unused   = ^bus.mem_addr[7:3];
  assign key_busy = (state != K_IDLE);

  // First edge after reset shows digit 0 without waiting a dwell
  assign nxt_idx = started ? scan_idx + 3'd1 : 3'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rd_data <= KEY_NONE;
      bus.rd_hit  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        seg_latch[i] <= 8'h00;
      end
    end else if (bus.en) begin
      bus.rd_hit <= hit;
      if (state == K_HELD && held_col == digit) begin
        bus.rd_data <= ~(8'h01 << held_row);
      end else begin
        bus.rd_data <= KEY_NONE;
      end
      if (hit && bus.mem_write_en) begin
        seg_latch[digit] <= bus.mem_write_data;
      end
    end
  end

  // seg and dig_n load together from the pre-edge latch value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      started  <= 1'b0;
      scan_idx <= 3'd0;
      seg      <= 8'h00;
      dig_n    <= 8'hFF;
    end else if (!started || dwell_tick) begin
      started  <= 1'b1;
      scan_idx <= nxt_idx;
      seg      <= seg_latch[nxt_idx];
      dig_n    <= ~(8'h01 << nxt_idx);
    end
  end

  // Counter reaches the phase end on its final tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= K_IDLE;
      held_col <= 3'd0;
      held_row <= 3'd0;
      ms_cnt   <= '0;
    end else begin
      unique case (state)
        K_IDLE: begin
          if (key_strobe) begin
            held_col <= key_code[2:0];
            held_row <= key_code[5:3];
            ms_cnt   <= CW'(KEY_HOLD_MS);
            state    <= K_HELD;
          end
        end
        K_HELD: begin
          if (ms_tick) begin
            if (ms_cnt <= CW'(1)) begin
              ms_cnt <= CW'(RELEASE_MS);
              state  <= K_RELEASE;
            end else begin
              ms_cnt <= ms_cnt - 1'b1;
            end
          end
        end
        K_RELEASE: begin
          if (ms_tick) begin
            if (ms_cnt <= CW'(1)) begin
              ms_cnt <= '0;
              state  <= K_IDLE;
            end else begin
              ms_cnt <= ms_cnt - 1'b1;
            end
          end
        end
        default: state <= K_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mk14_disp_kbd.sv
// Scoreboard bench for mk14_disp_kbd: bus reads, display scan, key timing.
// Expected read responses are queued at issue and popped by a monitor.
module tb_mk14_disp_kbd;

  localparam int H = 8;
  localparam int R = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_strobe = 1'b0;
  logic [5:0] key_code = 6'd0;
  logic       key_busy;
  logic [7:0] seg;
  logic [7:0] dig_n;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q [$];

  mk14_disp_kbd_if bus ();

  mk14_disp_kbd #(
    .CLOCK_FREQ_MHZ (1),
    .DIGIT_US       (4),
    .KEY_HOLD_MS    (H),
    .RELEASE_MS     (R),
    .SIM_TICK       (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .key_busy   (key_busy),
    .seg        (seg),
    .dig_n      (dig_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every enabled cycle presents one registered response
  initial begin
    logic       pend;
    logic [8:0] e;
    forever begin
      @(posedge clk);
      pend = bus.en && rst_n;
      #1;
      if (pend) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow actual %h required none",
                   {bus.rd_hit, bus.rd_data});
        end else begin
          e = exp_q.pop_front();
          if ({bus.rd_hit, bus.rd_data} !== e) begin
            errors++;
            $display("FAIL sb_read actual %h required %h",
                     {bus.rd_hit, bus.rd_data}, e);
          end
        end
      end
    end
  end

  task automatic bus_op(input logic [15:0] a,
                        input logic        we,
                        input logic [7:0]  wd,
                        input logic        eh,
                        input logic [7:0]  ed,
                        input logic        ks = 1'b0,
                        input logic [5:0]  kc = 6'd0);
    @(negedge clk);
    bus.en = 1'b1;
    bus.mem_addr = a;
    bus.mem_write_en = we;
    bus.mem_write_data = wd;
    key_strobe = ks;
    key_code = kc;
    exp_q.push_back({eh, ed});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.en = 1'b0;
      bus.mem_write_en = 1'b0;
      key_strobe = 1'b0;
    end
  endtask

  // Skip any dwell already in progress, then catch a fresh one
  task automatic wait_digit(input int idx,
                            input logic [7:0] exp,
                            input string name);
    logic [7:0] tgt;
    logic [7:0] one;
    int n;
    one = 8'h01;
    tgt = ~(one << idx);
    n = 0;
    while (dig_n == tgt && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (dig_n != tgt && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (dig_n != tgt) begin
      chk({name, "_timeout"}, {24'd0, dig_n}, {24'd0, tgt});
    end else begin
      chk(name, {24'd0, seg}, {24'd0, exp});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual running required done");
    $fatal(1, "timeout");
  end

  initial begin
    bus.en = 1'b0;
    bus.mem_addr = 16'h0000;
    bus.mem_write_en = 1'b0;
    bus.mem_write_data = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_data", {24'd0, bus.rd_data}, 32'hFF);
    chk("rst_rd_hit", {31'd0, bus.rd_hit}, 32'h0);
    chk("rst_seg", {24'd0, seg}, 32'h00);
    chk("rst_dig_n", {24'd0, dig_n}, 32'hFF);
    chk("rst_busy", {31'd0, key_busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_dig_n", {24'd0, dig_n}, 32'hFE);
    chk("first_seg", {24'd0, seg}, 32'h00);

    // Display latch and mirror decode
    bus_op(16'h0D02, 1'b1, 8'h3F, 1'b1, 8'hFF);
    idle(1);
    wait_digit(2, 8'h3F, "dig2_3f");
    wait_digit(0, 8'h00, "dig0_blank");
    wait_digit(7, 8'h00, "dig7_blank");
    bus_op(16'h0D0A, 1'b1, 8'h06, 1'b1, 8'hFF);
    idle(1);
    wait_digit(2, 8'h06, "dig2_mirror");
    bus_op(16'h0E02, 1'b1, 8'h99, 1'b0, 8'hFF);
    idle(1);
    wait_digit(2, 8'h06, "dig2_outside");

    // Press row 5 col 3, ignored second strobe, en freeze
    bus_op(16'h0D03, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 6'h2B);
    bus_op(16'h0D03, 1'b0, 8'h00, 1'b1, 8'hDF);
    bus_op(16'h0D04, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 6'h0C);
    bus_op(16'h0D04, 1'b0, 8'h00, 1'b1, 8'hFF);
    bus_op(16'h0D03, 1'b0, 8'h00, 1'b1, 8'hDF);
    @(negedge clk);
    bus.en = 1'b0;
    bus.mem_addr = 16'h0D01;
    bus.mem_write_en = 1'b1;
    bus.mem_write_data = 8'h5A;
    key_strobe = 1'b0;
    @(posedge clk);
    #1;
    chk("freeze_hit", {31'd0, bus.rd_hit}, 32'h1);
    chk("freeze_data", {24'd0, bus.rd_data}, 32'hDF);
    bus_op(16'h1000, 1'b0, 8'h00, 1'b0, 8'hFF);
    bus_op(16'h0D0B, 1'b0, 8'h00, 1'b1, 8'hDF);
    idle(H + R + 4);
    wait_digit(1, 8'h00, "dig1_frozen");

    // Cycle-exact hold and release timing
    for (int k = 0; k <= H + R + 1; k++) begin
      bus_op(16'h0D03, 1'b0, 8'h00, 1'b1,
             (k >= 1 && k <= H) ? 8'hDF : 8'hFF,
             (k == 0), 6'h2B);
      @(posedge clk);
      #1;
      chk($sformatf("busy_k%0d", k), {31'd0, key_busy},
          {31'd0, (k < H + R)});
    end
    idle(4);

    // Reset during a held key
    bus_op(16'h0D05, 1'b1, 8'h77, 1'b1, 8'hFF);
    bus_op(16'h0D03, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 6'h2B);
    bus_op(16'h0D03, 1'b0, 8'h00, 1'b1, 8'hDF);
    @(negedge clk);
    bus.en = 1'b0;
    bus.mem_write_en = 1'b0;
    key_strobe = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", {31'd0, key_busy}, 32'h0);
    chk("mid_rst_dig_n", {24'd0, dig_n}, 32'hFF);
    chk("mid_rst_rd_data", {24'd0, bus.rd_data}, 32'hFF);
    chk("mid_rst_rd_hit", {31'd0, bus.rd_hit}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_digit(2, 8'h00, "dig2_after_rst");
    wait_digit(5, 8'h00, "dig5_after_rst");
    bus_op(16'h0D03, 1'b0, 8'h00, 1'b1, 8'hFF);
    idle(3);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mk14_disp_kbd.md
# mk14_disp_kbd

Memory-mapped display/keyboard responder for the MK14 system. It sits on the core's memory bus at 0x0D00–0x0DFF. Core writes latch seven-segment patterns for eight digits. Core reads return the active-low keypad column state for the addressed digit. The block also multiplexes the LED display and stretches host key strobes into timed presses, so the monitor's scan/debounce loop sees each press and its release.

## Interface
- CLOCK_FREQ_MHZ, 50, clock ticks per microsecond
- BASE_ADDR, 16'h0D00, decode base; a hit is mem_addr[15:8] == BASE_ADDR[15:8]
- DIGIT_US, 1000, display dwell per digit in µs
- KEY_HOLD_MS, 100, time a key reads as pressed
- RELEASE_MS, 50, forced no-key gap after a press
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- en  in  1  bus-side enable; identical to the core's en
- mem_addr  in  16  core address
- mem_write_en  in  1  core write strobe, one cycle
- mem_write_data  in  8  core write data
- rd_data  out  8  registered read data
- rd_hit  out  1  registered; rd_data is valid for the address of the previous enabled cycle
- key_strobe  in  1  one-cycle request to press a key
- key_code  in  6  [2:0] column (digit), [5:3] row (data bit index); sampled with key_strobe
- key_busy  out  1  press or release gap in progress; strobes are dropped
- seg  out  8  segment pattern {dp,g,f,e,d,c,b,a}, active-high
- dig_n  out  8  digit enables, active-low, one-hot

## Operation
- Decode: hit = mem_addr[15:8] == BASE_ADDR[15:8]. digit = mem_addr[2:0]. mem_addr[7:3] is ignored, so the block mirrors every 8 bytes.
- Write, when en, hit and mem_write_en: seg_latch[digit] <= mem_write_data. Writes outside the window are ignored.
- Read, every enabled cycle:
  - rd_hit <= hit.
  - rd_data <= ~(8'h01 << held_row) if the key FSM is in K_HELD and held_col == digit; else 8'hFF.
  - There is no read strobe. A write cycle also updates rd_data.
- Display scan:
  - Free-running; ignores en.
  - scan_idx advances every DIGIT_US*CLOCK_FREQ_MHZ clocks and wraps 7→0.
  - seg <= seg_latch[scan_idx] and dig_n <= ~(8'h01 << scan_idx) in the same edge, so outputs never show a mismatched pair.
- Key FSM (free-running), states K_IDLE, K_HELD, K_RELEASE:
  - K_IDLE: key_strobe → capture held_col/held_row, load the ms counter with KEY_HOLD_MS, go to K_HELD.
  - K_HELD: decrement on each ms tick; at 0 load RELEASE_MS and go to K_RELEASE.
  - K_RELEASE: decrement on each ms tick; at 0 go to K_IDLE.
  - key_busy = (state != K_IDLE).
  - A key_strobe while busy is dropped with no effect.
- ms tick: one clock pulse every CLOCK_FREQ_MHZ*1000 clocks. Under SIMULATION it is one pulse per clock.
- Reset values: rd_data 8'hFF, rd_hit 0, seg 8'h00, dig_n 8'hFF, key_busy 0, all seg_latch 8'h00, scan_idx 0, tick and dwell counters 0, FSM K_IDLE.

## Timing
- Read latency is 1 cycle: address at edge N, rd_data valid after edge N+1. This matches the core's single MEM_WAIT cycle.
- A write at edge N affects seg no later than the next dwell boundary where scan_idx == digit.
- A write to the digit currently displayed shows at the next dwell boundary, not mid-dwell.
- The first scan output appears 1 clock after reset deasserts: dig_n 8'hFE, seg = seg_latch[0].
- key_strobe at edge N:
  - key_busy = 1 after edge N+1.
  - The key reads pressed from edge N+1 for KEY_HOLD_MS ms ±1 tick, then 0xFF for RELEASE_MS ms ±1 tick.
- en = 0 freezes rd_data, rd_hit and latch writes. Scan and key timing continue.
- Reset mid-press returns immediately to K_IDLE with the reset values. Latched patterns are lost.
- A simultaneous write and display update to the same digit: the display shows the old value this dwell.

## Structure
- mk14_pkg holds:
  - DISP_BASE 16'h0D00
  - the key_state_t enum {K_IDLE, K_HELD, K_RELEASE}
  - KEY_NONE 8'hFF
- Sub-module mk14_tick: parameterised divider giving a one-cycle ms pulse. It also provides the digit-dwell pulse via a second instance with DIGIT_US.
- The segment latch is an 8×8 register array, not RAM, because the scan reads it asynchronously.

## Test plan
- Write 0x3F to 0x0D02 → during scan_idx 2, dig_n 8'hFB and seg 8'h3F. Other digits show 0x00.
- Write 0x06 to 0x0D0A (mirror of digit 2) → digit 2 shows 0x06. Write to 0x0E02 → no change.
- key_strobe with key_code {row 5, col 3} → a read of 0x0D03 one cycle later returns 8'hDF. A read of 0x0D04 returns 8'hFF. rd_hit = 1. A read of 0x1000 gives rd_hit 0.
- SIMULATION timing: press then hold → 0xDF for KEY_HOLD_MS ticks, then 0xFF with key_busy 1 for RELEASE_MS ticks, then key_busy 0.
- A second key_strobe while key_busy → ignored; the held key code is unchanged.
- Assert rst_n low during K_HELD → next cycle key_busy 0, dig_n 8'hFF, rd_data 8'hFF. After release, the latch reads display 0x00.
